// File: rtl/exp_trap_unit_pkg.sv
// Shared definitions for the EXE-stage exception detect / trap handoff unit:
// mcause codes, memory access size encodings, SYSTEM-opcode decode helpers
// and the trap FSM state encoding.
package exp_trap_unit_pkg;

  // mcause exception codes
  localparam logic [3:0] exp_inst_illegal       = 4'd2;
  localparam logic [3:0] exp_load_addr_mis      = 4'd4;
  localparam logic [3:0] exp_load_access_fault  = 4'd5;
  localparam logic [3:0] exp_store_addr_mis     = 4'd6;
  localparam logic [3:0] exp_store_access_fault = 4'd7;
  localparam logic [3:0] exp_load_page_fault    = 4'd13;
  localparam logic [3:0] exp_store_page_fault   = 4'd15;

  // mem_size encodings
  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  // SYSTEM opcode and its funct3 groups
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_PRIV    = 3'b000;
  localparam logic [2:0] F3_CSRRW   = 3'b001;
  localparam logic [2:0] F3_CSRRS   = 3'b010;
  localparam logic [2:0] F3_CSRRC   = 3'b011;

  // inst[31:7] of the fixed-encoding privileged instructions
  localparam logic [24:0] ECALL_PFX  = 25'h000_0000;
  localparam logic [24:0] EBREAK_PFX = 25'h000_2000;
  localparam logic [24:0] MRET_PFX   = 25'h060_4000;
  localparam logic [6:0]  SFENCE_F7  = 7'b0001001;

  // Trap handoff FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } trap_state_e;

  // True when a SYSTEM-opcode word is one of the operations this core supports
  function automatic logic system_op_legal(input logic [31:0] inst);
    logic ok;
    ok = 1'b0;
    case (inst[14:12])
      F3_CSRRW, F3_CSRRS, F3_CSRRC: ok = 1'b1;
      F3_PRIV: ok = (inst[31:7] == ECALL_PFX) || (inst[31:7] == EBREAK_PFX) ||
                    (inst[31:7] == MRET_PFX) ||
                    ((inst[31:25] == SFENCE_F7) && (inst[11:7] == 5'd0));
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/exp_trap_unit_classify.sv
// Purely combinational priority classifier for the instruction in EXE:
// illegal > misaligned > page fault > access fault.
module exp_classify #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     EXP_W     = 4,
  parameter logic [XLEN-1:0] RAM_BASE  = 32'h8000_0000,
  parameter logic [XLEN-1:0] RAM_LIMIT = 32'h807F_FFFF,
  parameter logic [XLEN-1:0] DEV_BASE  = 32'h1000_0000,
  parameter logic [XLEN-1:0] DEV_LIMIT = 32'h1000_0008
) (
  input  logic             ex_valid_i,
  input  logic [31:0]      inst_i,
  input  logic             inst_legal_i,
  input  logic             mem_rd_i,
  input  logic             mem_wr_i,
  input  logic [1:0]       mem_size_i,
  input  logic [XLEN-1:0]  mem_addr_i,
  input  logic             sv32_en_i,
  input  logic             pt_fault_i,
  output logic             fault_o,
  output logic [EXP_W-1:0] code_o,
  output logic [XLEN-1:0]  tval_o
);
  import exp_trap_unit_pkg::*;

  logic mem_req;
  logic is_store;
  logic illegal;
  logic misaligned;
  logic in_map;

  // A simultaneous load+store request is treated as a store
  assign mem_req    = mem_rd_i | mem_wr_i;
  assign is_store   = mem_wr_i;
  assign illegal    = !inst_legal_i ||
                      ((inst_i[6:0] == OPC_SYSTEM) && !system_op_legal(inst_i)) ||
                      (mem_req && (mem_size_i == MEM_RSVD));
  assign misaligned = ((mem_size_i == MEM_HALF) && mem_addr_i[0]) ||
                      ((mem_size_i == MEM_WORD) && (mem_addr_i[1:0] != 2'b00));
  assign in_map     = ((mem_addr_i >= DEV_BASE) && (mem_addr_i <= DEV_LIMIT)) ||
                      ((mem_addr_i >= RAM_BASE) && (mem_addr_i <= RAM_LIMIT));

  // Pick the highest-priority cause and its tval
  always_comb begin
    fault_o = 1'b0;
    code_o  = '0;
    tval_o  = '0;
    if (ex_valid_i) begin
      if (illegal) begin
        fault_o = 1'b1;
        code_o  = EXP_W'(exp_inst_illegal);
        tval_o  = XLEN'(inst_i);
      end else if (mem_req && misaligned) begin
        fault_o = 1'b1;
        code_o  = is_store ? EXP_W'(exp_store_addr_mis) : EXP_W'(exp_load_addr_mis);
        tval_o  = mem_addr_i;
      end else if (mem_req && sv32_en_i && pt_fault_i) begin
        fault_o = 1'b1;
        code_o  = is_store ? EXP_W'(exp_store_page_fault) : EXP_W'(exp_load_page_fault);
        tval_o  = mem_addr_i;
      end else if (mem_req && !sv32_en_i && !in_map) begin
        fault_o = 1'b1;
        code_o  = is_store ? EXP_W'(exp_store_access_fault) : EXP_W'(exp_load_access_fault);
        tval_o  = mem_addr_i;
      end
    end
  end

endmodule

// File: rtl/exp_trap_unit.sv
// Registered exception capture and trap handoff toward the CSR unit.
// Holds one trap under a valid/ack handshake, stalls the pipeline while it is
// pending, then pulses flush for one cycle before accepting the next fault.
module exp_trap_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     EXP_W     = 4,
  parameter int unsigned     CNT_W     = 16,
  parameter logic [XLEN-1:0] RAM_BASE  = 32'h8000_0000,
  parameter logic [XLEN-1:0] RAM_LIMIT = 32'h807F_FFFF,
  parameter logic [XLEN-1:0] DEV_BASE  = 32'h1000_0000,
  parameter logic [XLEN-1:0] DEV_LIMIT = 32'h1000_0008
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [31:0]      inst,
  input  logic             inst_legal,
  input  logic [XLEN-1:0]  pc,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic [1:0]       mem_size,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic             sv32_en,
  input  logic             pt_fault,
  output logic             trap_valid,
  output logic [EXP_W-1:0] trap_code,
  output logic [XLEN-1:0]  trap_pc,
  output logic [XLEN-1:0]  trap_tval,
  input  logic             trap_ack,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] trap_count
);
  import exp_trap_unit_pkg::*;

  trap_state_e      state_q;
  logic             trap_valid_q;
  logic             stall_q;
  logic             flush_q;
  logic [EXP_W-1:0] code_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  tval_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic             fault;
  logic [EXP_W-1:0] fault_code;
  logic [XLEN-1:0]  fault_tval;

  exp_classify #(
    .XLEN      (XLEN),
    .EXP_W     (EXP_W),
    .RAM_BASE  (RAM_BASE),
    .RAM_LIMIT (RAM_LIMIT),
    .DEV_BASE  (DEV_BASE),
    .DEV_LIMIT (DEV_LIMIT)
  ) u_classify (
    .ex_valid_i   (ex_valid),
    .inst_i       (inst),
    .inst_legal_i (inst_legal),
    .mem_rd_i     (mem_rd),
    .mem_wr_i     (mem_wr),
    .mem_size_i   (mem_size),
    .mem_addr_i   (mem_addr),
    .sv32_en_i    (sv32_en),
    .pt_fault_i   (pt_fault),
    .fault_o      (fault),
    .code_o       (fault_code),
    .tval_o       (fault_tval)
  );

  // Saturating increment: the counter sticks at all-ones
  assign count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);

  // Trap FSM with capture registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      trap_valid_q <= 1'b0;
      stall_q      <= 1'b0;
      flush_q      <= 1'b0;
      code_q       <= '0;
      pc_q         <= '0;
      tval_q       <= '0;
      count_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          flush_q <= 1'b0;
          if (fault) begin
            code_q       <= fault_code;
            pc_q         <= pc;
            tval_q       <= fault_tval;
            count_q      <= count_d;
            trap_valid_q <= 1'b1;
            stall_q      <= 1'b1;
            state_q      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (trap_ack) begin
            trap_valid_q <= 1'b0;
            stall_q      <= 1'b0;
            flush_q      <= 1'b1;
            state_q      <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          flush_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          trap_valid_q <= 1'b0;
          stall_q      <= 1'b0;
          flush_q      <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign trap_valid = trap_valid_q;
  assign stall      = stall_q;
  assign flush      = flush_q;
  assign trap_code  = code_q;
  assign trap_pc    = pc_q;
  assign trap_tval  = tval_q;
  assign trap_count = count_q;

endmodule

// File: tb/tb_exp_trap_unit.sv
// Bench for exp_trap_unit: directed vectors with literal expectations plus a
// cycle-level behavioural model compared against every output each cycle.
module tb_exp_trap_unit;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] inst;
  logic        inst_legal;
  logic [31:0] pc;
  logic        mem_rd, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic        sv32_en, pt_fault;
  logic        trap_valid;
  logic [3:0]  trap_code;
  logic [31:0] trap_pc, trap_tval;
  logic        trap_ack;
  logic        stall, flush;
  logic [CNT_W-1:0] trap_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exp_trap_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .inst(inst),
    .inst_legal(inst_legal), .pc(pc), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_size(mem_size), .mem_addr(mem_addr), .sv32_en(sv32_en),
    .pt_fault(pt_fault), .trap_valid(trap_valid), .trap_code(trap_code),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .trap_ack(trap_ack),
    .stall(stall), .flush(flush), .trap_count(trap_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        f;
    logic [3:0]  code;
    logic [31:0] tval;
  } cls_t;

  function automatic cls_t m_classify(input logic v, input logic [31:0] i, input logic lg,
                                      input logic rd, input logic wr, input logic [1:0] sz,
                                      input logic [31:0] a, input logic sv, input logic pf);
    cls_t r;
    logic req, st, sys, sys_ok, in_map;
    int unsigned nb;
    r      = '0;
    req    = rd | wr;
    st     = wr;
    sys    = (i[6:0] == 7'b1110011);
    sys_ok = (i[14:12] == 3'd1) || (i[14:12] == 3'd2) || (i[14:12] == 3'd3) ||
             (i == 32'h0000_0073) || (i == 32'h0010_0073) || (i == 32'h3020_0073) ||
             ((i[31:25] == 7'b0001001) && (i[14:0] == 15'h0073));
    in_map = ((a >= 32'h1000_0000) && (a <= 32'h1000_0008)) ||
             ((a >= 32'h8000_0000) && (a <= 32'h807F_FFFF));
    nb     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (!v) return r;
    if (!lg || (sys && !sys_ok) || (req && sz == 2'd3)) begin
      r.f = 1'b1; r.code = 4'd2; r.tval = i;
    end else if (req && ((a % nb) != 0)) begin
      r.f = 1'b1; r.code = st ? 4'd6 : 4'd4; r.tval = a;
    end else if (req && sv && pf) begin
      r.f = 1'b1; r.code = st ? 4'd15 : 4'd13; r.tval = a;
    end else if (req && !sv && !in_map) begin
      r.f = 1'b1; r.code = st ? 4'd7 : 4'd5; r.tval = a;
    end
    return r;
  endfunction

  cls_t        cls_now;
  logic        model_live = 1'b0;
  logic        m_pending, m_flush;
  logic [3:0]  m_code;
  logic [31:0] m_pc, m_tval;
  int          m_cnt;

  assign cls_now = m_classify(ex_valid, inst, inst_legal, mem_rd, mem_wr, mem_size,
                              mem_addr, sv32_en, pt_fault);

  // One pending trap at a time; ack retires it into a single flush cycle
  always @(posedge clk) begin
    model_live <= 1'b1;
    if (!rst_n) begin
      m_pending <= 1'b0; m_flush <= 1'b0; m_code <= '0;
      m_pc <= '0; m_tval <= '0; m_cnt <= 0;
    end else if (m_flush) begin
      m_flush <= 1'b0;
    end else if (m_pending) begin
      if (trap_ack) begin
        m_pending <= 1'b0;
        m_flush   <= 1'b1;
      end
    end else if (cls_now.f) begin
      m_pending <= 1'b1;
      m_code    <= cls_now.code;
      m_tval    <= cls_now.tval;
      m_pc      <= pc;
      m_cnt     <= (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("cmp_trap_valid", 32'(trap_valid), 32'(m_pending));
      chk("cmp_stall", 32'(stall), 32'(m_pending));
      chk("cmp_flush", 32'(flush), 32'(m_flush));
      chk("cmp_trap_code", 32'(trap_code), 32'(m_code));
      chk("cmp_trap_pc", trap_pc, m_pc);
      chk("cmp_trap_tval", trap_tval, m_tval);
      chk("cmp_trap_count", 32'(trap_count), 32'(m_cnt));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic v, input logic [31:0] i, input logic lg, input logic rd,
                       input logic wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic sv, input logic pf);
    ex_valid = v; inst = i; inst_legal = lg; mem_rd = rd; mem_wr = wr;
    mem_size = sz; mem_addr = a; sv32_en = sv; pt_fault = pf;
  endtask

  task automatic idle_in();
    drive(1'b0, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
  endtask

  // Present one EXE instruction, check capture, then ack and check flush
  task automatic run_trap(input string nm, input logic [31:0] i, input logic lg,
                          input logic rd, input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic sv, input logic pf,
                          input logic exp_trap, input logic [3:0] exp_code,
                          input logic [31:0] exp_tval);
    logic [31:0] my_pc;
    @(negedge clk);
    pc = pc + 32'd4;
    my_pc = pc;
    drive(1'b1, i, lg, rd, wr, sz, a, sv, pf);
    @(negedge clk);
    idle_in();
    chk({nm, "_valid"}, 32'(trap_valid), 32'(exp_trap));
    chk({nm, "_stall"}, 32'(stall), 32'(exp_trap));
    if (exp_trap) begin
      chk({nm, "_code"}, 32'(trap_code), 32'(exp_code));
      chk({nm, "_tval"}, trap_tval, exp_tval);
      chk({nm, "_pc"}, trap_pc, my_pc);
    end
    trap_ack = 1'b1;
    @(negedge clk);
    trap_ack = 1'b0;
    chk({nm, "_flush"}, 32'(flush), 32'(exp_trap));
    @(negedge clk);
    chk({nm, "_flush_end"}, 32'(flush), 32'h0);
  endtask

  localparam logic [31:0] LW   = 32'h0000_2003;
  localparam logic [31:0] SW   = 32'h0000_2023;
  localparam logic [31:0] BADS = 32'h0000_4073;  // SYSTEM funct3=100, unsupported

  initial begin
    pc = 32'h8000_0000;
    trap_ack = 1'b0;
    idle_in();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(trap_valid), 32'h0);
    chk("rst_code", 32'(trap_code), 32'h0);
    chk("rst_count", 32'(trap_count), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    rst_n = 1'b1;

    run_trap("lw_mis", LW, 1, 1, 0, 2'b10, 32'h8000_0002, 0, 0, 1, 4'd4, 32'h8000_0002);
    chk("count_after_first", 32'(trap_count), 32'd1);
    run_trap("sw_acc", SW, 1, 0, 1, 2'b10, 32'h0000_1000, 0, 0, 1, 4'd7, 32'h0000_1000);
    run_trap("sw_pf", SW, 1, 0, 1, 2'b10, 32'h0000_1000, 1, 1, 1, 4'd15, 32'h0000_1000);
    run_trap("lb_dev_top", LW, 1, 1, 0, 2'b00, 32'h1000_0008, 0, 0, 0, 4'd0, 32'h0);
    run_trap("lb_ram_top", LW, 1, 1, 0, 2'b00, 32'h807F_FFFF, 0, 0, 0, 4'd0, 32'h0);
    run_trap("lb_dev_over", LW, 1, 1, 0, 2'b00, 32'h1000_0009, 0, 0, 1, 4'd5, 32'h1000_0009);
    run_trap("lb_ram_over", LW, 1, 1, 0, 2'b00, 32'h8080_0000, 0, 0, 1, 4'd5, 32'h8080_0000);
    run_trap("lb_dev_base", LW, 1, 1, 0, 2'b00, 32'h1000_0000, 0, 0, 0, 4'd0, 32'h0);
    run_trap("lb_below_ram", LW, 1, 1, 0, 2'b00, 32'h7FFF_FFFF, 0, 0, 1, 4'd5, 32'h7FFF_FFFF);
    run_trap("lh_mis", LW, 1, 1, 0, 2'b01, 32'h8000_0001, 0, 0, 1, 4'd4, 32'h8000_0001);
    run_trap("lh_ok", LW, 1, 1, 0, 2'b01, 32'h8000_0002, 0, 0, 0, 4'd0, 32'h0);
    run_trap("sys_illegal", BADS, 1, 1, 0, 2'b10, 32'h8000_0003, 0, 0, 1, 4'd2, BADS);
    run_trap("ecall", 32'h0000_0073, 1, 0, 0, 2'b00, 32'h0, 0, 0, 0, 4'd0, 32'h0);
    run_trap("mret", 32'h3020_0073, 1, 0, 0, 2'b00, 32'h0, 0, 0, 0, 4'd0, 32'h0);
    run_trap("sfence", 32'h1200_0073, 1, 0, 0, 2'b00, 32'h0, 0, 0, 0, 4'd0, 32'h0);
    run_trap("csrrsi", 32'h3000_6073, 1, 0, 0, 2'b00, 32'h0, 0, 0, 1, 4'd2, 32'h3000_6073);
    run_trap("not_legal", 32'hFFFF_FFFF, 0, 0, 0, 2'b00, 32'h0, 0, 0, 1, 4'd2, 32'hFFFF_FFFF);
    run_trap("size_rsvd", LW, 1, 1, 0, 2'b11, 32'h8000_0000, 0, 0, 1, 4'd2, LW);
    run_trap("lw_pf", LW, 1, 1, 0, 2'b10, 32'h4000_0000, 1, 1, 1, 4'd13, 32'h4000_0000);
    run_trap("sv32_nopf", LW, 1, 1, 0, 2'b10, 32'h4000_0000, 1, 0, 0, 4'd0, 32'h0);
    run_trap("rdwr_store", SW, 1, 1, 1, 2'b10, 32'h8000_0006, 0, 0, 1, 4'd6, 32'h8000_0006);
    run_trap("sb_acc", SW, 1, 0, 1, 2'b00, 32'h1000_0009, 0, 0, 1, 4'd7, 32'h1000_0009);

    // Handshake: long hold, fault during HOLD/FLUSH ignored, back-to-back capture
    @(negedge clk);
    drive(1, LW, 1, 1, 0, 2'b10, 32'h8000_0006, 0, 0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      drive(1, SW, 1, 0, 1, 2'b10, 32'h0000_1000, 0, 0);
      chk("hold_valid", 32'(trap_valid), 32'h1);
      chk("hold_code", 32'(trap_code), 32'd4);
      chk("hold_tval", trap_tval, 32'h8000_0006);
      @(negedge clk);
    end
    trap_ack = 1'b1;
    @(negedge clk);
    trap_ack = 1'b0;
    chk("hs_flush", 32'(flush), 32'h1);
    chk("hs_valid_off", 32'(trap_valid), 32'h0);
    drive(1, SW, 1, 0, 1, 2'b10, 32'h0000_2000, 0, 0);
    @(negedge clk);
    chk("hs_flush_once", 32'(flush), 32'h0);
    chk("hs_flush_nocap", 32'(trap_valid), 32'h0);
    drive(1, SW, 1, 0, 1, 2'b10, 32'h0000_3000, 0, 0);
    @(negedge clk);
    idle_in();
    chk("b2b_valid", 32'(trap_valid), 32'h1);
    chk("b2b_tval", trap_tval, 32'h0000_3000);

    // Reset during HOLD discards the trap with no flush
    rst_n = 1'b0;
    trap_ack = 1'b1;
    @(negedge clk);
    chk("rhold_valid", 32'(trap_valid), 32'h0);
    chk("rhold_stall", 32'(stall), 32'h0);
    chk("rhold_flush", 32'(flush), 32'h0);
    chk("rhold_count", 32'(trap_count), 32'h0);
    chk("rhold_tval", trap_tval, 32'h0);
    rst_n = 1'b1;
    trap_ack = 1'b0;
    @(negedge clk);
    chk("rhold_noflush", 32'(flush), 32'h0);

    // Saturation of the trap counter
    for (int k = 0; k < CNT_MAX; k++) begin
      drive(1, LW, 1, 1, 0, 2'b00, 32'h0000_0100, 0, 0);
      @(negedge clk);
      idle_in();
      trap_ack = 1'b1;
      @(negedge clk);
      trap_ack = 1'b0;
      @(negedge clk);
    end
    chk("sat_full", 32'(trap_count), 32'(CNT_MAX));
    run_trap("sat_more", LW, 1, 1, 0, 2'b00, 32'h0000_0100, 0, 0, 1, 4'd5, 32'h0000_0100);
    chk("sat_hold", 32'(trap_count), 32'(CNT_MAX));

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
